spart: RTL and testbench

SPART -- requirements
Module: spart

---
 rtl/spart_pkg.sv | 28 ++
 rtl/spart_if.sv | 21 ++
 rtl/spart_baud_gen.sv | 34 +++
 rtl/spart.sv | 245 ++++++++++++++++++++++++
 tb/tb_spart.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART serial port: register addresses,
// bit-timing constants and the transmit/receive state types.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    // 16 baud enables per serial bit; receiver checks the start bit mid-way
    localparam logic [3:0] TICK_LAST = 4'd15;
    localparam logic [3:0] TICK_MID  = 4'd7;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/spart_if.sv
// Processor-side control/status signals of the SPART (the 8-bit data bus
// itself stays a plain inout port on the top module).
interface spart_if;

    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (
        output iocs, iorw, ioaddr,
        input  rda, tbr
    );

    modport slave (
        input  iocs, iorw, ioaddr,
        output rda, tbr
    );

endinterface

// File: rtl/spart_baud_gen.sv
// Baud-rate enable generator: 16-bit down counter that pulses en for one
// cycle at zero and reloads from the divisor (period = divisor + 1).
module spart_baud_gen #(
    parameter logic [15:0] DB_RESET = 16'd650
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] divisor,
    input  logic        load,
    input  logic [15:0] load_value,
    output logic        en
);

    logic [15:0] cnt;

    // count down, reload at zero; an explicit load restarts the period at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= DB_RESET;
        end else if (load) begin
            cnt <= load_value;
        end else if (cnt == '0) begin
            cnt <= divisor;
        end else begin
            cnt <= cnt - 16'd1;
        end
    end

    // enable pulse while the counter sits at zero
    always_comb begin
        en = (cnt == '0);
    end

endmodule

// File: rtl/spart.sv
// SPART: simple programmable asynchronous receiver/transmitter with an
// 8-bit processor bus, programmable baud divisor and 16x oversampling.
module spart
    import spart_pkg::*;
#(
    parameter logic [15:0] DB_RESET = 16'd650
) (
    input  logic        clk,
    input  logic        rst,
    spart_if.slave      bus,
    inout  wire  [7:0]  databus,
    output logic        txd,
    input  logic        rxd
);

    logic        bus_wr;
    logic        bus_rd;
    logic [15:0] divisor;
    logic        baud_load;
    logic [15:0] baud_load_value;
    logic        baud_en;
    logic [7:0]  rd_data;

    tx_state_t   tx_state, tx_state_next;
    logic [7:0]  tx_buf, tx_buf_next;
    logic [2:0]  tx_bit, tx_bit_next;
    logic [3:0]  tx_tick, tx_tick_next;

    rx_state_t   rx_state, rx_state_next;
    logic [7:0]  rx_shift, rx_shift_next;
    logic [2:0]  rx_bit, rx_bit_next;
    logic [3:0]  rx_tick, rx_tick_next;
    logic        rx_s1, rx_s2, rx_prev;
    logic        rx_done;
    logic [7:0]  rx_buf;
    logic        rda_q;

    // bus access decode and divisor-high reload request
    always_comb begin
        bus_wr          = bus.iocs && !bus.iorw;
        bus_rd          = bus.iocs && bus.iorw;
        baud_load       = bus_wr && (bus.ioaddr == ADDR_DB_HI);
        baud_load_value = {databus, divisor[7:0]};
    end

    // divisor register, written a byte at a time
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divisor <= DB_RESET;
        end else if (bus_wr && bus.ioaddr == ADDR_DB_LO) begin
            divisor[7:0] <= databus;
        end else if (bus_wr && bus.ioaddr == ADDR_DB_HI) begin
            divisor[15:8] <= databus;
        end
    end

    spart_baud_gen #(
        .DB_RESET(DB_RESET)
    ) u_baud_gen (
        .clk       (clk),
        .rst       (rst),
        .divisor   (divisor),
        .load      (baud_load),
        .load_value(baud_load_value),
        .en        (baud_en)
    );

    // transmit state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_buf   <= '0;
            tx_bit   <= '0;
            tx_tick  <= '0;
        end else begin
            tx_state <= tx_state_next;
            tx_buf   <= tx_buf_next;
            tx_bit   <= tx_bit_next;
            tx_tick  <= tx_tick_next;
        end
    end

    // transmit next-state: 16 enables per bit; writes accepted only when idle
    always_comb begin
        tx_state_next = tx_state;
        tx_buf_next   = tx_buf;
        tx_bit_next   = tx_bit;
        tx_tick_next  = tx_tick;
        case (tx_state)
            TX_IDLE: begin
                if (bus_wr && bus.ioaddr == ADDR_BUF) begin
                    tx_buf_next   = databus;
                    tx_bit_next   = '0;
                    tx_tick_next  = '0;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (baud_en) begin
                    tx_tick_next = tx_tick + 4'd1;
                    if (tx_tick == TICK_LAST) begin
                        tx_state_next = TX_DATA;
                    end
                end
            end
            TX_DATA: begin
                if (baud_en) begin
                    tx_tick_next = tx_tick + 4'd1;
                    if (tx_tick == TICK_LAST) begin
                        if (tx_bit == 3'd7) begin
                            tx_state_next = TX_STOP;
                        end else begin
                            tx_bit_next = tx_bit + 3'd1;
                        end
                    end
                end
            end
            TX_STOP: begin
                if (baud_en) begin
                    tx_tick_next = tx_tick + 4'd1;
                    if (tx_tick == TICK_LAST) begin
                        tx_state_next = TX_IDLE;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // serial output and ready flag decoded from state, so reset forces them at once
    always_comb begin
        bus.tbr = (tx_state == TX_IDLE);
        case (tx_state)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = tx_buf[tx_bit];
            default:  txd = 1'b1;
        endcase
    end

    // two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // receive state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rx_shift <= '0;
            rx_bit   <= '0;
            rx_tick  <= '0;
        end else begin
            rx_state <= rx_state_next;
            rx_shift <= rx_shift_next;
            rx_bit   <= rx_bit_next;
            rx_tick  <= rx_tick_next;
        end
    end

    // receive next-state: mid-start check, then one sample every 16 enables
    always_comb begin
        rx_state_next = rx_state;
        rx_shift_next = rx_shift;
        rx_bit_next   = rx_bit;
        rx_tick_next  = rx_tick;
        rx_done       = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s2) begin
                    rx_tick_next  = '0;
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (baud_en) begin
                    if (rx_tick == TICK_MID) begin
                        rx_tick_next  = '0;
                        rx_bit_next   = '0;
                        rx_state_next = rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tick_next = rx_tick + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (baud_en) begin
                    rx_tick_next = rx_tick + 4'd1;
                    if (rx_tick == TICK_LAST) begin
                        rx_shift_next[rx_bit] = rx_s2;
                        if (rx_bit == 3'd7) begin
                            rx_state_next = RX_STOP;
                        end else begin
                            rx_bit_next = rx_bit + 3'd1;
                        end
                    end
                end
            end
            RX_STOP: begin
                if (baud_en) begin
                    rx_tick_next = rx_tick + 4'd1;
                    if (rx_tick == TICK_LAST) begin
                        rx_done       = rx_s2;
                        rx_state_next = RX_IDLE;
                    end
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // rx buffer and data-available flag; a completing byte beats a clearing read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_buf <= '0;
            rda_q  <= 1'b0;
        end else if (rx_done) begin
            rx_buf <= rx_shift;
            rda_q  <= 1'b1;
        end else if (bus_rd && bus.ioaddr == ADDR_BUF) begin
            rda_q  <= 1'b0;
        end
    end

    // read data mux and status flag export
    always_comb begin
        bus.rda = rda_q;
        case (bus.ioaddr)
            ADDR_BUF:    rd_data = rx_buf;
            ADDR_STATUS: rd_data = {6'b0, rda_q, bus.tbr};
            ADDR_DB_LO:  rd_data = divisor[7:0];
            default:     rd_data = divisor[15:8];
        endcase
    end

    assign databus = bus_rd ? rd_data : 8'bz;

endmodule

// File: tb/tb_spart.sv
// Self-checking bench for spart: a per-cycle transmitter model derived from
// baud-enable arithmetic plus directed bus/receiver vectors.
module tb_spart;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_dout = 8'h00;
    wire  [7:0] databus;
    logic       txd;
    logic       rxd;
    logic       loop = 1'b0;
    logic       rx_drive = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    spart_if ifc();

    assign databus = tb_oe ? tb_dout : 8'bz;
    assign rxd = loop ? txd : rx_drive;

    spart #(.DB_RESET(16'd650)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (ifc),
        .databus(databus),
        .txd    (txd),
        .rxd    (rxd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transmitter model ----------------
    int         n = 0;
    int         mref = 0;
    int         mdiv = 650;
    logic [7:0] mlo = 8'h8A;
    bit         mactive = 1'b0;
    logic [9:0] mframe = '1;
    int         mens = 0;

    function automatic bit men(input int c);
        return (c >= mref) && (((c - mref) % (mdiv + 1)) == mdiv);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_tbr", {15'd0, ifc.tbr}, 16'd1);
            check("rst_txd", {15'd0, txd}, 16'd1);
            mref = n + 1;
            mdiv = 650;
            mlo = 8'h8A;
            mactive = 1'b0;
        end else begin
            check("tbr", {15'd0, ifc.tbr}, {15'd0, !mactive});
            check("txd", {15'd0, txd}, {15'd0, (mactive ? mframe[mens / 16] : 1'b1)});
            if (mactive) begin
                if (men(n)) mens++;
                if (mens == 160) mactive = 1'b0;
            end else if (ifc.iocs && !ifc.iorw && ifc.ioaddr == 2'b00) begin
                mactive = 1'b1;
                mens = 0;
                mframe = {1'b1, databus, 1'b0};
            end
            if (ifc.iocs && !ifc.iorw && ifc.ioaddr == 2'b10) mlo = databus;
            if (ifc.iocs && !ifc.iorw && ifc.ioaddr == 2'b11) begin
                mdiv = int'({databus, mlo});
                mref = n + 1;
            end
        end
        n++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
        ifc.iocs = 1'b1;
        ifc.iorw = 1'b0;
        ifc.ioaddr = addr;
        tb_dout = data;
        tb_oe = 1'b1;
        tick();
        ifc.iocs = 1'b0;
        tb_oe = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [7:0] data);
        ifc.iocs = 1'b1;
        ifc.iorw = 1'b1;
        ifc.ioaddr = addr;
        tb_oe = 1'b0;
        #2;
        data = databus;
        tick();
        ifc.iocs = 1'b0;
        ifc.iorw = 1'b0;
    endtask

    task automatic expect_read(input string name, input logic [1:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(addr, d);
        check(name, {8'd0, d}, {8'd0, exp});
    endtask

    task automatic wait_rda(input string name, input int limit);
        int c = 0;
        while (ifc.rda !== 1'b1 && c < limit) begin
            tick();
            c++;
        end
        check(name, {15'd0, ifc.rda}, 16'd1);
    endtask

    task automatic wait_tbr(input string name, input int limit);
        int c = 0;
        while (ifc.tbr !== 1'b1 && c < limit) begin
            tick();
            c++;
        end
        check(name, {15'd0, ifc.tbr}, 16'd1);
    endtask

    task automatic send_raw(input logic [9:0] frm);
        for (int i = 0; i < 10; i++) begin
            rx_drive = frm[i];
            repeat (64) tick();
        end
        rx_drive = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int         off;
        int         k;
        logic [9:0] bits;

        ifc.iocs = 1'b0;
        ifc.iorw = 1'b0;
        ifc.ioaddr = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // reset state
        check("reset_tbr", {15'd0, ifc.tbr}, 16'd1);
        check("reset_rda", {15'd0, ifc.rda}, 16'd0);
        check("reset_txd", {15'd0, txd}, 16'd1);
        tb_dout = 8'h96;
        tb_oe = 1'b1;
        #1 check("bus_released", {8'd0, databus}, 16'h0096);
        tb_oe = 1'b0;
        expect_read("status_reset", 2'b01, 8'h01);
        expect_read("rxbuf_reset", 2'b00, 8'h00);
        expect_read("div_lo_reset", 2'b10, 8'h8A);
        expect_read("div_hi_reset", 2'b11, 8'h02);
        bus_write(2'b01, 8'hFF);
        expect_read("status_wr_ignored", 2'b01, 8'h01);

        // divisor 3, then transmit A5 aligned to a fresh baud period
        bus_write(2'b10, 8'h03);
        bus_write(2'b11, 8'h00);
        repeat (3) tick();
        bus_write(2'b00, 8'hA5);
        check("tbr_after_write", {15'd0, ifc.tbr}, 16'd0);
        off = 0;
        k = 0;
        bits = '0;
        while (ifc.tbr == 1'b0 && off < 1000) begin
            if (k < 10 && off == 32 + 64 * k) begin
                bits[k] = txd;
                k++;
            end
            if (off == 100) bus_write(2'b00, 8'h3C);
            else tick();
            off++;
        end
        check("tx_busy_cycles", off[15:0], 16'd640);
        check("tx_bits_a5", {6'd0, bits}, 16'b0000_0011_0100_1010);
        expect_read("div_lo", 2'b10, 8'h03);
        expect_read("div_hi", 2'b11, 8'h00);

        // loopback 5A
        loop = 1'b1;
        bus_write(2'b00, 8'h5A);
        wait_rda("rda_5a", 1000);
        expect_read("status_rx_busy_tx", 2'b01, 8'h02);
        expect_read("rx_5a", 2'b00, 8'h5A);
        check("rda_cleared", {15'd0, ifc.rda}, 16'd0);
        wait_tbr("tbr_5a", 200);

        // false start and framing error
        loop = 1'b0;
        rx_drive = 1'b0;
        repeat (20) tick();
        rx_drive = 1'b1;
        repeat (300) tick();
        check("rda_false_start", {15'd0, ifc.rda}, 16'd0);
        send_raw({1'b0, 8'h77, 1'b0});
        repeat (100) tick();
        check("rda_framing", {15'd0, ifc.rda}, 16'd0);
        send_raw({1'b1, 8'hC3, 1'b0});
        repeat (50) tick();
        check("rda_raw_c3", {15'd0, ifc.rda}, 16'd1);
        expect_read("rx_raw_c3", 2'b00, 8'hC3);

        // two bytes without a read: second overwrites
        loop = 1'b1;
        bus_write(2'b00, 8'h11);
        wait_tbr("tbr_11", 1000);
        check("rda_after_11", {15'd0, ifc.rda}, 16'd1);
        bus_write(2'b00, 8'h22);
        wait_tbr("tbr_22", 1000);
        repeat (10) tick();
        check("rda_overrun", {15'd0, ifc.rda}, 16'd1);
        expect_read("rx_overrun", 2'b00, 8'h22);
        check("rda_after_overrun_read", {15'd0, ifc.rda}, 16'd0);

        // reset in the middle of a frame
        bus_write(2'b00, 8'h0F);
        repeat (100) tick();
        #3 rst = 1'b0;
        #1;
        check("midtx_reset_txd", {15'd0, txd}, 16'd1);
        check("midtx_reset_tbr", {15'd0, ifc.tbr}, 16'd1);
        check("midtx_reset_rda", {15'd0, ifc.rda}, 16'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();
        expect_read("div_lo_after_reset", 2'b10, 8'h8A);
        expect_read("status_after_reset", 2'b01, 8'h01);
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
